dmem_responder: RTL and testbench

//  Data-memory responder on the far side of the core's load/store port: the core initiates, this block answers.

---
 rtl/rv32_pkg.sv | 27 ++
 rtl/dmem_lane_align.sv | 51 +++++
 rtl/dmem_responder.sv | 168 ++++++++++++++++
 tb/tb_dmem_responder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 load/store definitions: funct3 encodings, responder FSM states,
// and the funct3 legality rule used by the data-memory responder.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Stores only have B/H/W; loads additionally have the unsigned BU/HU forms.
    function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 > F3_W);
        end
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store byte-enable mask and replicated
// write data, plus load byte/half selection with sign or zero extension.
module dmem_lane_align
    import rv32_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdword,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdword[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rdword[31:16] : i_rdword[15:0];

    // Store data is replicated across lanes so the mask alone picks the target bytes.
    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_wdata;
        case (i_funct3)
            F3_B: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            F3_H: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            F3_W:    o_be = 4'b1111;
            default: o_be = 4'b0000;
        endcase
    end

    always_comb begin
        o_rdata = '0;
        case (i_funct3)
            F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_rdata = {24'd0, w_byte};
            F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
            F3_HU:   o_rdata = {16'd0, w_half};
            F3_W:    o_rdata = i_rdword;
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word-addressed RAM serving RV32 byte/half/word loads
// and stores over valid/ready, with programmable wait states and fault flagging.
module dmem_responder
    import rv32_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN     = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  LAST_CNT = 4'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
    localparam bit          NO_WAIT  = (WAIT_CYCLES == 0);

    state_t      r_state;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [3:0]  r_wait_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;

    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_idle;
    logic          w_we;
    logic [31:0]   w_addr;
    logic [31:0]   w_wdata;
    logic [2:0]    w_funct3;
    logic [31:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_misal;
    logic          w_oor;
    logic          w_err;
    logic          w_enter_resp;
    logic          w_commit;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_al;
    logic [31:0]   w_rdword;
    logic [31:0]   w_rdata_ext;
    logic [31:0]   w_rsp_rdata;

    // With zero wait states the response is formed on the accept edge, so the
    // live request stands in for the latch while idle.
    assign w_idle   = (r_state == ST_IDLE);
    assign w_we     = w_idle ? req_we     : r_we;
    assign w_addr   = w_idle ? req_addr   : r_addr;
    assign w_wdata  = w_idle ? req_wdata  : r_wdata;
    assign w_funct3 = w_idle ? req_funct3 : r_funct3;

    assign w_off   = w_addr - BASE_ADDR;
    assign w_idx   = w_off[AW+1:2];
    assign w_misal = (((w_funct3 == F3_H) || (w_funct3 == F3_HU)) && w_addr[0])
                   || ((w_funct3 == F3_W) && (w_addr[1:0] != 2'b00));
    assign w_oor   = (w_off >= SPAN);
    assign w_err   = w_misal || w_oor || funct3_illegal(w_we, w_funct3);

    assign w_enter_resp = (w_idle && r_req_ready && req_valid && NO_WAIT)
                        || ((r_state == ST_WAIT) && (r_wait_cnt == LAST_CNT));
    assign w_commit     = w_enter_resp && w_we && !w_err;

    assign w_rdword    = r_mem[w_idx];
    assign w_rsp_rdata = (w_we || w_err) ? 32'd0 : w_rdata_ext;

    dmem_lane_align u_lane_align (
        .i_funct3  (w_funct3),
        .i_addr_lo (w_addr[1:0]),
        .i_wdata   (w_wdata),
        .i_rdword  (w_rdword),
        .o_be      (w_be),
        .o_wdata   (w_wdata_al),
        .o_rdata   (w_rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_al[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_wait_cnt  <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_funct3    <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_funct3    <= req_funct3;
                        r_req_ready <= 1'b0;
                        r_wait_cnt  <= 4'd0;
                        if (NO_WAIT) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_rsp_rdata;
                            r_rsp_err   <= w_err;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == LAST_CNT) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_rsp_rdata;
                        r_rsp_err   <= w_err;
                        r_wait_cnt  <= 4'd0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: loads, stores, lane masking,
// fault detection, response back-pressure and reset during a pending store.
module tb_dmem_responder;

    localparam int WAIT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_funct3 = 3'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, expv);
        end
    endtask

    task automatic accept(input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] f3);
        int n = 0;
        @(negedge clk);
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wd;
        req_funct3 = f3;
        req_valid  = 1'b1;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Counts cycles after the accept edge until rsp_valid is seen by the next sampling edge.
    task automatic wait_rsp(input string tag);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 20);
        chk({tag, "_latency"}, 32'(lat), 32'(WAIT + 1));
    endtask

    task automatic finish_rsp(input string tag);
        exp_t e;
        chk({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
        end else begin
            e.rdata = 32'hxxxxxxxx;
            e.err   = 1'bx;
        end
        chk({tag, "_rdata"}, rsp_rdata, e.rdata);
        chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e.err});
        $display("xact %s rdata=%08h err=%0b", tag, rsp_rdata, rsp_err);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_req_ready_after"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_rsp_valid_after"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [2:0] f3,
                        input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        accept(we, addr, wd, f3);
        wait_rsp(tag);
        finish_rsp(tag);
    endtask

    initial begin
        // Reset state, with a request offered that must be ignored.
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        req_valid = 1'b0;
        rst = 1'b0;

        // Word store and load-back.
        xact("sw_10",  1'b1, 32'h10, 32'hDEADBEEF, 3'd2, 32'h0, 1'b0);
        xact("lw_10",  1'b0, 32'h10, 32'h0, 3'd2, 32'hDEADBEEF, 1'b0);

        // Sub-word loads with sign/zero extension.
        xact("lb_13",  1'b0, 32'h13, 32'h0, 3'd0, 32'hFFFFFFDE, 1'b0);
        xact("lbu_13", 1'b0, 32'h13, 32'h0, 3'd4, 32'h000000DE, 1'b0);
        xact("lh_12",  1'b0, 32'h12, 32'h0, 3'd1, 32'hFFFFDEAD, 1'b0);
        xact("lhu_10", 1'b0, 32'h10, 32'h0, 3'd5, 32'h0000BEEF, 1'b0);
        xact("lbu_10", 1'b0, 32'h10, 32'h0, 3'd4, 32'h000000EF, 1'b0);

        // Byte and half stores touch only their lanes.
        xact("sb_11",    1'b1, 32'h11, 32'hFFFFFF55, 3'd0, 32'h0, 1'b0);
        xact("lw_10_sb", 1'b0, 32'h10, 32'h0, 3'd2, 32'hDEAD55EF, 1'b0);
        xact("sh_12",    1'b1, 32'h12, 32'h9999ABCD, 3'd1, 32'h0, 1'b0);
        xact("lw_10_sh", 1'b0, 32'h10, 32'h0, 3'd2, 32'hABCD55EF, 1'b0);

        // Faults: misaligned, out of range, illegal funct3; memory left unchanged.
        xact("lw_12_mis",  1'b0, 32'h12, 32'h0, 3'd2, 32'h0, 1'b1);
        xact("sh_11_mis",  1'b1, 32'h11, 32'h00001234, 3'd1, 32'h0, 1'b1);
        xact("sw_3_ill",   1'b1, 32'h10, 32'h12345678, 3'd3, 32'h0, 1'b1);
        xact("lw_10_kept", 1'b0, 32'h10, 32'h0, 3'd2, 32'hABCD55EF, 1'b0);
        xact("lw_oor",     1'b0, 32'h1000, 32'h0, 3'd2, 32'h0, 1'b1);
        xact("sw_oor",     1'b1, 32'h1000, 32'h5A5A5A5A, 3'd2, 32'h0, 1'b1);
        xact("lw_f3_3",    1'b0, 32'h10, 32'h0, 3'd3, 32'h0, 1'b1);
        xact("lw_f3_6",    1'b0, 32'h10, 32'h0, 3'd6, 32'h0, 1'b1);
        xact("sw_top",     1'b1, 32'hFFC, 32'hCAFEF00D, 3'd2, 32'h0, 1'b0);
        xact("lw_top",     1'b0, 32'hFFC, 32'h0, 3'd2, 32'hCAFEF00D, 1'b0);

        // Back-pressure: response held stable while rsp_ready is low.
        begin
            exp_t e;
            e.rdata = 32'hABCD55EF;
            e.err   = 1'b0;
            sb_q.push_back(e);
        end
        accept(1'b0, 32'h10, 32'h0, 3'd2);
        wait_rsp("hold");
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h30;
        req_wdata  = 32'h77777777;
        req_funct3 = 3'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rsp_rdata", rsp_rdata, 32'hABCD55EF);
            chk("hold_rsp_err", {31'd0, rsp_err}, 32'd0);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        finish_rsp("hold");

        // Reset while a store waits to commit: store dropped, outputs reset at once.
        xact("sw_20", 1'b1, 32'h20, 32'h11111111, 3'd2, 32'h0, 1'b0);
        accept(1'b1, 32'h20, 32'hAAAAAAAA, 3'd2);
        rst = 1'b1;
        #1;
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst_rsp_rdata", rsp_rdata, 32'd0);
        chk("midrst_rsp_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        xact("lw_20", 1'b0, 32'h20, 32'h0, 3'd2, 32'h11111111, 1'b0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
